// File: rtl/lcd_bcd_counter_view_if.sv
// Pixel-stream and glyph-ROM bus between the st7735 driver side and the counter view.
interface lcd_bcd_counter_view_if #(
  parameter int ADDR_W = 11,
  parameter int INT_W  = 4
);
  logic [7:0]        x;
  logic [6:0]        y;
  logic              next_pixel;
  logic [15:0]       color;
  logic [ADDR_W-1:0] rom_addr;
  logic [INT_W-1:0]  rom_data;

  // Driver + ROM side: supplies coordinates, pixel strobe and ROM read data.
  modport master (
    output x, y, next_pixel, rom_data,
    input  color, rom_addr
  );

  // View side: consumes coordinates and ROM data, produces colour and ROM address.
  modport slave (
    input  x, y, next_pixel, rom_data,
    output color, rom_addr
  );
endinterface

// File: rtl/lcd_bcd_counter_view.sv
// Multi-digit BCD counter with fractional prescaler, rendered onto the st7735
// pixel stream through a glyph ROM; display value is latched once per frame.
module lcd_bcd_counter_view #(
  parameter int          DIGITS      = 4,
  parameter int          CLK_HZ      = 12000000,
  parameter int          TICK_HZ     = 1,
  parameter int          ACC_BITS    = 28,
  parameter int          GLYPH_COLS  = 20,
  parameter int          GLYPH_ROWS  = 10,
  parameter int          SCALE_SHIFT = 1,
  parameter int          X_ORG       = 0,
  parameter int          Y_ORG       = 0,
  parameter int          H_RES       = 160,
  parameter int          V_RES       = 128,
  parameter int          INT_W       = 4,
  parameter logic [15:0] FG_MASK     = 16'hFFFF,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter int          ADDR_W      = $clog2(10 * GLYPH_COLS * GLYPH_ROWS)
) (
  input  logic                     clk,
  input  logic                     reset,
  lcd_bcd_counter_view_if.slave    pix,
  input  logic                     cnt_en,
  input  logic                     cnt_down,
  input  logic                     cnt_clear,
  output logic [4*DIGITS-1:0]      digits,
  output logic                     wrap
);

  localparam logic [63:0] INC_FULL =
    ((64'd1 << (ACC_BITS - 1)) * 64'(TICK_HZ)) / 64'(CLK_HZ);
  localparam logic [ACC_BITS-1:0] INC = INC_FULL[ACC_BITS-1:0];

  localparam int CW = GLYPH_COLS << SCALE_SHIFT;
  localparam int CH = GLYPH_ROWS << SCALE_SHIFT;

  logic [ACC_BITS-1:0] r_acc;
  logic [4*DIGITS-1:0] r_digits;
  logic [4*DIGITS-1:0] r_snap;
  logic                r_wrap;
  logic                r_in_band_q;
  logic [15:0]         r_color;

  logic                w_tick;
  logic [4*DIGITS-1:0] w_next;
  logic                w_carry;
  logic [15:0]         w_dx;
  logic [15:0]         w_dy;
  logic                w_in_band;
  logic [15:0]         w_base;
  logic [3:0]          w_d;
  logic [15:0]         w_col;
  logic [15:0]         w_row;
  logic [ADDR_W-1:0]   w_rom_addr;
  logic [4:0]          w_r5;
  logic [5:0]          w_g6;
  logic [15:0]         w_shade;

  assign w_tick = cnt_en & r_acc[ACC_BITS-1];

  // Prescaler: dropping the MSB on overflow keeps the fractional remainder.
  always_ff @(posedge clk) begin
    if (reset || cnt_clear) begin
      r_acc <= '0;
    end else if (cnt_en) begin
      if (r_acc[ACC_BITS-1]) r_acc <= {1'b0, r_acc[ACC_BITS-2:0]} + INC;
      else                   r_acc <= r_acc + INC;
    end
  end

  // Ripple increment/decrement across BCD digits; final carry is the wrap.
  always_comb begin
    w_next  = r_digits;
    w_carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (!cnt_down) begin
          if (r_digits[4*i +: 4] >= 4'd9) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (r_digits[4*i +: 4] == 4'd0) begin
            w_next[4*i +: 4] = 4'd9;
          end else begin
            w_next[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  // Counter state and single-cycle wrap pulse; clear beats a same-cycle tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digits <= '0;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (cnt_clear) begin
        r_digits <= '0;
      end else if (w_tick) begin
        r_digits <= w_next;
        r_wrap   <= w_carry;
      end
    end
  end

  // Latch the live value on the last pixel of each frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
    end else if (pix.next_pixel && (pix.x == 8'(H_RES - 1)) &&
                 (pix.y == 7'(V_RES - 1))) begin
      r_snap <= r_digits;
    end
  end

  // Pixel-to-glyph mapping; the cell is picked by a constant threshold chain.
  always_comb begin
    w_dx      = 16'({8'b0, pix.x}) - 16'(X_ORG);
    w_dy      = 16'({9'b0, pix.y}) - 16'(Y_ORG);
    w_in_band = !w_dx[15] && (w_dx < 16'(DIGITS * CW)) &&
                !w_dy[15] && (w_dy < 16'(CH));
    w_base    = '0;
    w_d       = r_snap[4*(DIGITS-1) +: 4];
    for (int unsigned k = 1; k < DIGITS; k++) begin
      if (w_dx >= 16'(k * CW)) begin
        w_base = 16'(k * CW);
        w_d    = r_snap[4*(DIGITS-1-k) +: 4];
      end
    end
    w_col      = (w_dx - w_base) >> SCALE_SHIFT;
    w_row      = w_dy >> SCALE_SHIFT;
    w_rom_addr = '0;
    if (w_in_band) begin
      w_rom_addr = ADDR_W'(32'(w_d) * 32'(GLYPH_COLS * GLYPH_ROWS) +
                           32'(w_row) * 32'(GLYPH_COLS) + 32'(w_col));
    end
  end

  assign pix.rom_addr = w_rom_addr;

  // Gray shade: intensity left-aligned into each RGB565 field.
  always_comb begin
    w_r5    = 5'(({pix.rom_data, 6'b0}) >> (INT_W + 1));
    w_g6    = 6'(({pix.rom_data, 6'b0}) >> INT_W);
    w_shade = {w_r5, w_g6, w_r5} & FG_MASK;
  end

  // Band flag delayed to line up with the registered ROM read.
  always_ff @(posedge clk) begin
    if (reset) r_in_band_q <= 1'b0;
    else       r_in_band_q <= w_in_band;
  end

  // Colour register updated only when the driver takes a pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_color <= '0;
    end else if (pix.next_pixel) begin
      if (!r_in_band_q || (pix.rom_data == '0)) r_color <= BG_COLOR;
      else                                       r_color <= w_shade;
    end
  end

  assign pix.color = r_color;
  assign digits    = r_digits;
  assign wrap      = r_wrap;

endmodule

// File: tb/tb_lcd_bcd_counter_view.sv
// Directed bench for lcd_bcd_counter_view: counter timing/wrap/clear, render table,
// frame snapshot and mid-frame reset.
module tb_lcd_bcd_counter_view;

  logic        clk = 1'b0;
  logic        reset;
  logic        cnt_en, cnt_down, cnt_clear;
  logic [15:0] digits;
  logic        wrap;
  logic        rom_force;
  logic [3:0]  rom_val;
  int          total = 0;
  int          bad   = 0;
  int          wrap_cnt = 0;

  lcd_bcd_counter_view_if #(.ADDR_W(11), .INT_W(4)) pif();

  lcd_bcd_counter_view #(.CLK_HZ(4), .TICK_HZ(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .pix       (pif),
    .cnt_en    (cnt_en),
    .cnt_down  (cnt_down),
    .cnt_clear (cnt_clear),
    .digits    (digits),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  // Behavioural glyph ROM: one-cycle registered read returning address LSBs.
  always @(posedge clk) begin
    pif.rom_data <= rom_force ? rom_val : pif.rom_addr[3:0];
  end

  // Count cycles on which wrap is high.
  always @(negedge clk) begin
    if (wrap) wrap_cnt = wrap_cnt + 1;
  end

  initial begin
    #1500000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic        frc;
    logic [3:0]  val;
    logic [10:0] addr;
    logic [15:0] color;
  } vec_t;

  vec_t vt[10];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_pixel();
    pif.next_pixel = 1'b1;
    step(1);
    pif.next_pixel = 1'b0;
  endtask

  task automatic frame_end();
    pif.x = 8'd159;
    pif.y = 7'd127;
    step(2);
    pulse_pixel();
  endtask

  initial begin
    vt[0] = '{8'd0,   7'd0,   1'b0, 4'h0, 11'd0200, 16'h8410};
    vt[1] = '{8'd45,  7'd3,   1'b0, 4'h0, 11'd0422, 16'h630C};
    vt[2] = '{8'd45,  7'd3,   1'b1, 4'hF, 11'd0422, 16'hF79E};
    vt[3] = '{8'd10,  7'd100, 1'b1, 4'hF, 11'd0000, 16'h0000};
    vt[4] = '{8'd45,  7'd3,   1'b1, 4'h0, 11'd0422, 16'h0000};
    vt[5] = '{8'd159, 7'd19,  1'b0, 4'h0, 11'd0999, 16'h738E};
    vt[6] = '{8'd100, 7'd20,  1'b1, 4'hF, 11'd0000, 16'h0000};
    vt[7] = '{8'd80,  7'd10,  1'b0, 4'h0, 11'd0700, 16'hC618};
    vt[8] = '{8'd79,  7'd0,   1'b0, 4'h0, 11'd0419, 16'h3186};
    vt[9] = '{8'd39,  7'd19,  1'b0, 4'h0, 11'd0399, 16'hF79E};

    reset = 1'b1; cnt_en = 1'b0; cnt_down = 1'b0; cnt_clear = 1'b0;
    rom_force = 1'b0; rom_val = 4'h0;
    pif.x = 8'd0; pif.y = 7'd0; pif.next_pixel = 1'b0;
    step(2);
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_wrap", 32'(wrap), 32'h0);
    chk("reset_color", 32'(pif.color), 32'h0);
    chk("reset_rom_addr", 32'(pif.rom_addr), 32'd0);
    reset = 1'b0;

    // Prescaler cadence: first tick on the 5th enabled edge, then every 4.
    cnt_en = 1'b1;
    step(4);  chk("pre_first_tick", 32'(digits), 32'h0000);
    step(1);  chk("first_tick", 32'(digits), 32'h0001);
    step(3);  chk("hold_between_ticks", 32'(digits), 32'h0001);
    step(1);  chk("second_tick", 32'(digits), 32'h0002);
    chk("no_wrap_early", 32'(wrap_cnt), 32'd0);

    // Up to 9999, then wrap to 0000.
    step(4 * 9997); chk("reach_9999", 32'(digits), 32'h9999);
    step(3);  chk("hold_9999", 32'(digits), 32'h9999);
    chk("no_wrap_before", 32'(wrap), 32'h0);
    step(1);  chk("wrap_up_digits", 32'(digits), 32'h0000);
    chk("wrap_up_pulse", 32'(wrap), 32'h1);
    step(1);  chk("wrap_up_one_cycle", 32'(wrap), 32'h0);
    chk("wrap_count_1", 32'(wrap_cnt), 32'd1);

    // Down from 0000 wraps to 9999.
    cnt_down = 1'b1;
    step(3);  chk("wrap_down_digits", 32'(digits), 32'h9999);
    chk("wrap_down_pulse", 32'(wrap), 32'h1);
    step(1);  chk("wrap_down_one_cycle", 32'(wrap), 32'h0);

    // 0100 down to 0099 (borrow across two digits, no wrap).
    cnt_down = 1'b0; cnt_clear = 1'b1;
    step(1);  cnt_clear = 1'b0;
    chk("clear_digits", 32'(digits), 32'h0000);
    step(401); chk("reach_0100", 32'(digits), 32'h0100);
    cnt_down = 1'b1;
    step(4);  chk("down_0099", 32'(digits), 32'h0099);
    chk("wrap_count_2", 32'(wrap_cnt), 32'd2);

    // Clear coinciding with a tick at 0042.
    cnt_down = 1'b0; cnt_clear = 1'b1;
    step(1);  cnt_clear = 1'b0;
    step(169); chk("reach_0042", 32'(digits), 32'h0042);
    step(3);  cnt_clear = 1'b1;
    step(1);  cnt_clear = 1'b0;
    chk("clear_on_tick_digits", 32'(digits), 32'h0000);
    chk("clear_on_tick_wrap", 32'(wrap), 32'h0);
    step(4);  chk("clear_acc_no_early_tick", 32'(digits), 32'h0000);
    step(1);  chk("clear_acc_tick_at_5", 32'(digits), 32'h0001);

    // Disable for 1000 cycles: accumulator and digits both frozen.
    step(2);  cnt_en = 1'b0;
    step(1000); chk("freeze_digits", 32'(digits), 32'h0001);
    cnt_en = 1'b1;
    step(1);  chk("resume_not_yet", 32'(digits), 32'h0001);
    step(1);  chk("resume_tick_acc_held", 32'(digits), 32'h0002);
    chk("wrap_count_final", 32'(wrap_cnt), 32'd2);

    // Bring to 1234 and latch it into the display.
    step(4 * 1232); cnt_en = 1'b0;
    chk("reach_1234", 32'(digits), 32'h1234);
    frame_end();

    // Render table against snapshot 1234.
    for (int i = 0; i < 10; i++) begin
      pif.x = vt[i].x; pif.y = vt[i].y;
      rom_force = vt[i].frc; rom_val = vt[i].val;
      step(1);
      chk($sformatf("rom_addr[%0d]", i), 32'(pif.rom_addr), 32'(vt[i].addr));
      step(1);
      pulse_pixel();
      chk($sformatf("color[%0d]", i), 32'(pif.color), 32'(vt[i].color));
    end
    // Colour holds with next_pixel low even as ROM data changes.
    rom_force = 1'b1; rom_val = 4'h5;
    step(3);
    chk("color_hold", 32'(pif.color), 32'h0000F79E);
    rom_force = 1'b0;

    // Anti-tearing: live digits change, display keeps the old frame value.
    cnt_en = 1'b1;
    step(4);  cnt_en = 1'b0;
    chk("live_1235", 32'(digits), 32'h1235);
    pif.x = 8'd120; pif.y = 7'd0;
    step(1);  chk("tear_old_snap", 32'(pif.rom_addr), 32'd800);
    frame_end();
    pif.x = 8'd120; pif.y = 7'd0;
    step(1);  chk("tear_new_snap", 32'(pif.rom_addr), 32'd1000);
    pif.x = 8'd0;
    step(1);  chk("tear_new_cell0", 32'(pif.rom_addr), 32'd200);

    // Reset mid-frame on an in-band, non-zero pixel.
    pif.x = 8'd45; pif.y = 7'd3;
    step(2);
    pif.next_pixel = 1'b1; reset = 1'b1;
    step(1);
    pif.next_pixel = 1'b0; reset = 1'b0;
    chk("midreset_color", 32'(pif.color), 32'h0);
    chk("midreset_digits", 32'(digits), 32'h0000);
    chk("midreset_snap_addr", 32'(pif.rom_addr), 32'd22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
